// File: rtl/id_pool_tracker_if.sv
// Interface bundling the allocation, issue, writeback and retire signals of id_pool_tracker.
// Master is the pipeline side; slave is the tracker.
interface id_pool_tracker_if #(
  parameter int LOG2_IDS     = 3,
  parameter int RETIRE_PORTS = 2,
  parameter int NUM_WB_PORTS = 3
);
  localparam int RCW = $clog2(RETIRE_PORTS + 1);

  // Handshakes: an ID is granted when alloc_req & alloc_ready, issued when issue & issue_valid;
  // requests without the matching ready/valid are ignored and need not be held.
  logic                             alloc_req;
  logic [LOG2_IDS-1:0]              alloc_id;
  logic                             alloc_ready;
  logic                             flush;
  logic                             issue_valid;
  logic [LOG2_IDS-1:0]              issue_id;
  logic                             issue;
  logic                             issue_needs_wb;
  logic [NUM_WB_PORTS-1:0]          wb_valid;
  logic [NUM_WB_PORTS*LOG2_IDS-1:0] wb_id;
  logic [RETIRE_PORTS-1:0]          retire_valid;
  logic [RETIRE_PORTS*LOG2_IDS-1:0] retire_ids;
  logic [RCW-1:0]                   retire_count;
  logic [LOG2_IDS:0]                post_issue_count;

  modport master (
    output alloc_req, flush, issue, issue_needs_wb, wb_valid, wb_id,
    input  alloc_id, alloc_ready, issue_valid, issue_id,
    input  retire_valid, retire_ids, retire_count, post_issue_count
  );

  modport slave (
    input  alloc_req, flush, issue, issue_needs_wb, wb_valid, wb_id,
    output alloc_id, alloc_ready, issue_valid, issue_id,
    output retire_valid, retire_ids, retire_count, post_issue_count
  );
endinterface

// File: rtl/id_pool_tracker.sv
// Circular ID pool: allocate, issue, wait for writeback, retire in order up to RETIRE_PORTS per cycle.
// Optional ID_POOL_TRACKER_STATS_EN adds stat_retired / stat_full_cycles counters.
module id_pool_tracker #(
  parameter int LOG2_IDS     = 3,
  parameter int RETIRE_PORTS = 2,
  parameter int NUM_WB_PORTS = 3
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ID_POOL_TRACKER_STATS_EN
  output logic [31:0] stat_retired,
  output logic [31:0] stat_full_cycles,
`endif
  id_pool_tracker_if.slave bus
);
  localparam int IDS = 1 << LOG2_IDS;
  localparam int CW  = LOG2_IDS + 1;
  localparam int RCW = $clog2(RETIRE_PORTS + 1);
  localparam logic [CW:0] POOL_SIZE = (CW+1)'(IDS);

  logic [LOG2_IDS-1:0] alloc_ptr, issue_ptr, retire_ptr;
  logic [CW-1:0]       pre_cnt, post_cnt;
  logic [IDS-1:0]      pending;

  logic [RETIRE_PORTS-1:0]          retire_valid_q;
  logic [RETIRE_PORTS*LOG2_IDS-1:0] retire_ids_q;
  logic [RCW-1:0]                   retire_count_q;

  logic                             alloc_req, flush, issue, issue_needs_wb;
  logic [NUM_WB_PORTS-1:0]          wb_valid;
  logic [NUM_WB_PORTS*LOG2_IDS-1:0] wb_id;

  logic                             alloc_ready, issue_valid, alloc_fire, issue_fire;
  logic [CW:0]                      occupancy;
  logic [RETIRE_PORTS-1:0]          rv_next;
  logic [RETIRE_PORTS*LOG2_IDS-1:0] rids_next;
  logic [RCW-1:0]                   rcnt_next;
  logic [IDS-1:0]                   pending_next;
  logic [LOG2_IDS-1:0]              slot;
  logic                             run;

  assign alloc_req      = bus.alloc_req;
  assign flush          = bus.flush;
  assign issue          = bus.issue;
  assign issue_needs_wb = bus.issue_needs_wb;
  assign wb_valid       = bus.wb_valid;
  assign wb_id          = bus.wb_id;

  assign bus.alloc_id         = alloc_ptr;
  assign bus.alloc_ready      = alloc_ready;
  assign bus.issue_valid      = issue_valid;
  assign bus.issue_id         = issue_ptr;
  assign bus.retire_valid     = retire_valid_q;
  assign bus.retire_ids       = retire_ids_q;
  assign bus.retire_count     = retire_count_q;
  assign bus.post_issue_count = post_cnt;

  always_comb begin
    // Occupancy uses registered counts only: same-cycle retires free space one cycle later.
    occupancy   = {1'b0, pre_cnt} + {1'b0, post_cnt};
    alloc_ready = occupancy < POOL_SIZE;
    issue_valid = (pre_cnt != '0);
    alloc_fire  = alloc_req & alloc_ready & ~flush;
    issue_fire  = issue & issue_valid;

    run       = 1'b1;
    slot      = '0;
    rv_next   = '0;
    rids_next = '0;
    rcnt_next = '0;
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      slot       = retire_ptr + LOG2_IDS'(i);
      run        = run & (post_cnt > CW'(i)) & ~pending[slot];
      rv_next[i] = run;
      rcnt_next  = rcnt_next + RCW'(run);
      rids_next[i*LOG2_IDS +: LOG2_IDS] = slot;
    end

    pending_next = pending;
    if (issue_fire) pending_next[issue_ptr] = issue_needs_wb;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (wb_valid[p]) pending_next[wb_id[p*LOG2_IDS +: LOG2_IDS]] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr      <= '0;
      issue_ptr      <= '0;
      retire_ptr     <= '0;
      pre_cnt        <= '0;
      post_cnt       <= '0;
      pending        <= '0;
      retire_valid_q <= '0;
      retire_count_q <= '0;
      for (int i = 0; i < RETIRE_PORTS; i++) begin
        retire_ids_q[i*LOG2_IDS +: LOG2_IDS] <= LOG2_IDS'(i);
      end
    end else begin
      // Flush discards pre-issue IDs; an issue in the same cycle still survives.
      if (flush) begin
        alloc_ptr <= issue_ptr + LOG2_IDS'(issue_fire);
        pre_cnt   <= '0;
      end else begin
        alloc_ptr <= alloc_ptr + LOG2_IDS'(alloc_fire);
        pre_cnt   <= pre_cnt + CW'(alloc_fire) - CW'(issue_fire);
      end
      issue_ptr      <= issue_ptr + LOG2_IDS'(issue_fire);
      retire_ptr     <= retire_ptr + LOG2_IDS'(rcnt_next);
      post_cnt       <= post_cnt + CW'(issue_fire) - CW'(rcnt_next);
      pending        <= pending_next;
      retire_valid_q <= rv_next;
      retire_ids_q   <= rids_next;
      retire_count_q <= rcnt_next;
    end
  end

`ifdef ID_POOL_TRACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_retired     <= '0;
      stat_full_cycles <= '0;
    end else begin
      stat_retired     <= stat_retired + 32'(retire_count_q);
      stat_full_cycles <= stat_full_cycles + 32'(alloc_req & ~alloc_ready);
    end
  end
`endif

  // A writeback must target a pending ID and must not collide with the ID being set pending.
  for (genvar p = 0; p < NUM_WB_PORTS; p++) begin : g_wb_chk
    a_wb_pending : assert property (@(posedge clk) disable iff (rst)
      wb_valid[p] |-> pending[wb_id[p*LOG2_IDS +: LOG2_IDS]]);
    a_wb_no_set_clash : assert property (@(posedge clk) disable iff (rst)
      !(issue_fire && issue_needs_wb && wb_valid[p] &&
        (wb_id[p*LOG2_IDS +: LOG2_IDS] == issue_ptr)));
  end
endmodule

// File: tb/tb_id_pool_tracker.sv
// Bench for id_pool_tracker: directed scenarios plus randomized traffic against a queue-based model.
module tb_id_pool_tracker;
  localparam int L   = 3;
  localparam int IDS = 8;
  localparam int RP  = 2;
  localparam int NWB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_pool_tracker_if #(.LOG2_IDS(L), .RETIRE_PORTS(RP), .NUM_WB_PORTS(NWB)) bus ();

  id_pool_tracker #(.LOG2_IDS(L), .RETIRE_PORTS(RP), .NUM_WB_PORTS(NWB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: IDs waiting to issue, IDs in flight in program order, pending flags.
  int       pre_q[$];
  logic [L-1:0] exp_q[$];
  bit       m_pend[IDS];
  int       m_next, m_total, m_rn, m_base;

  task automatic model_update();
    int  n, iid;
    bit  ready, ivalid, ifire, afire;
    if (rst) begin
      pre_q.delete();
      exp_q.delete();
      foreach (m_pend[k]) m_pend[k] = 1'b0;
      m_next = 0; m_total = 0; m_rn = 0; m_base = 0;
      return;
    end
    ready  = (pre_q.size() + exp_q.size()) < IDS;
    ivalid = pre_q.size() != 0;
    n = 0;
    while (n < RP && n < exp_q.size() && !m_pend[exp_q[n]]) n++;
    m_base  = m_total;
    m_rn    = n;
    m_total = m_total + n;
    repeat (n) void'(exp_q.pop_front());
    ifire = bus.issue && ivalid;
    afire = bus.alloc_req && ready && !bus.flush;
    if (ifire) begin
      iid = pre_q.pop_front();
      exp_q.push_back(L'(iid));
      m_pend[iid] = bus.issue_needs_wb;
    end
    for (int p = 0; p < NWB; p++)
      if (bus.wb_valid[p]) m_pend[bus.wb_id[p*L +: L]] = 1'b0;
    if (bus.flush) begin
      if (pre_q.size() != 0) m_next = pre_q[0];
      pre_q.delete();
    end else if (afire) begin
      pre_q.push_back(m_next);
      m_next = (m_next + 1) % IDS;
    end
  endtask

  task automatic drive(input logic a, input logic f, input logic i, input logic w);
    bus.alloc_req      = a;
    bus.flush          = f;
    bus.issue          = i;
    bus.issue_needs_wb = w;
    bus.wb_valid       = '0;
    bus.wb_id          = '0;
  endtask

  task automatic set_wb(input int p, input int id);
    bus.wb_valid[p]      = 1'b1;
    bus.wb_id[p*L +: L]  = L'(id);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready got=%b exp=1", bus.alloc_ready); end
    n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid got=%b exp=0", bus.issue_valid); end
    n_checks++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL reset_retire_valid got=%b exp=00", bus.retire_valid); end
    n_checks++; if (bus.retire_count !== 2'd0) begin n_fail++; $display("FAIL reset_retire_count got=%0d exp=0", bus.retire_count); end
    n_checks++; if (bus.retire_ids !== {3'd1, 3'd0}) begin n_fail++; $display("FAIL reset_retire_ids got=%h exp=%h", bus.retire_ids, {3'd1, 3'd0}); end
    n_checks++; if (bus.post_issue_count !== 4'd0) begin n_fail++; $display("FAIL reset_post_count got=%0d exp=0", bus.post_issue_count); end
    n_checks++; if (bus.alloc_id !== 3'd0) begin n_fail++; $display("FAIL reset_alloc_id got=%0d exp=0", bus.alloc_id); end
  endtask

  task automatic test_alloc_fill();
    do_reset();
    for (int i = 0; i < IDS; i++) begin
      drive(1, 0, 0, 0);
      n_checks++; if (bus.alloc_id !== L'(i) || bus.alloc_ready !== 1'b1) begin
        n_fail++; $display("FAIL fill_alloc i=%0d got id=%0d rdy=%b exp id=%0d rdy=1", i, bus.alloc_id, bus.alloc_ready, i);
      end
      tick();
    end
    n_checks++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got=%b exp=0", bus.alloc_ready); end
    tick();
    n_checks++; if (bus.alloc_id !== 3'd0 || bus.alloc_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_ninth_ignored got id=%0d rdy=%b exp id=0 rdy=0", bus.alloc_id, bus.alloc_ready);
    end
    n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_id !== 3'd0) begin
      n_fail++; $display("FAIL fill_issue_head got v=%b id=%0d exp v=1 id=0", bus.issue_valid, bus.issue_id);
    end
  endtask

  task automatic test_retire_order();
    do_reset();
    drive(1, 0, 0, 0); repeat (3) tick();
    drive(0, 0, 1, 1); repeat (3) tick();
    drive(0, 0, 0, 0); set_wb(0, 0); set_wb(1, 1); set_wb(2, 2); tick();
    drive(0, 0, 0, 0);
    n_checks++; if (bus.post_issue_count !== 4'd3 || bus.retire_valid !== 2'b00) begin
      n_fail++; $display("FAIL order_pre got post=%0d rv=%b exp post=3 rv=00", bus.post_issue_count, bus.retire_valid);
    end
    tick();
    n_checks++; if (bus.retire_valid !== 2'b11 || bus.retire_ids !== {3'd1, 3'd0} || bus.retire_count !== 2'd2 || bus.post_issue_count !== 4'd1) begin
      n_fail++; $display("FAIL order_pair got rv=%b ids=%h cnt=%0d post=%0d exp rv=11 ids=%h cnt=2 post=1",
        bus.retire_valid, bus.retire_ids, bus.retire_count, bus.post_issue_count, {3'd1, 3'd0});
    end
    tick();
    n_checks++; if (bus.retire_valid !== 2'b01 || bus.retire_ids[2:0] !== 3'd2 || bus.retire_count !== 2'd1 || bus.post_issue_count !== 4'd0) begin
      n_fail++; $display("FAIL order_single got rv=%b id0=%0d cnt=%0d post=%0d exp rv=01 id0=2 cnt=1 post=0",
        bus.retire_valid, bus.retire_ids[2:0], bus.retire_count, bus.post_issue_count);
    end
    tick();
    n_checks++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL order_idle got rv=%b exp=00", bus.retire_valid); end
  endtask

  task automatic test_writeback();
    do_reset();
    drive(1, 0, 0, 0); repeat (2) tick();
    drive(0, 0, 1, 1); repeat (2) tick();
    drive(0, 0, 0, 0); set_wb(2, 1); tick();
    drive(0, 0, 0, 0); tick();
    n_checks++; if (bus.retire_valid !== 2'b00 || bus.post_issue_count !== 4'd2) begin
      n_fail++; $display("FAIL wb_younger_blocked got rv=%b post=%0d exp rv=00 post=2", bus.retire_valid, bus.post_issue_count);
    end
    set_wb(2, 0); tick();
    drive(0, 0, 0, 0);
    n_checks++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL wb_no_forward got rv=%b exp=00", bus.retire_valid); end
    tick();
    n_checks++; if (bus.retire_valid !== 2'b11 || bus.retire_ids !== {3'd1, 3'd0} || bus.post_issue_count !== 4'd0) begin
      n_fail++; $display("FAIL wb_pair got rv=%b ids=%h post=%0d exp rv=11 ids=%h post=0",
        bus.retire_valid, bus.retire_ids, bus.post_issue_count, {3'd1, 3'd0});
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0); repeat (5) tick();
    drive(0, 0, 1, 1); repeat (2) tick();
    drive(1, 1, 1, 1); tick();
    drive(0, 0, 0, 0);
    n_checks++; if (bus.issue_valid !== 1'b0 || bus.alloc_id !== 3'd3 || bus.post_issue_count !== 4'd3) begin
      n_fail++; $display("FAIL flush_state got iv=%b aid=%0d post=%0d exp iv=0 aid=3 post=3",
        bus.issue_valid, bus.alloc_id, bus.post_issue_count);
    end
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_id !== 3'd3 || bus.alloc_id !== 3'd4) begin
      n_fail++; $display("FAIL flush_realloc got iv=%b iid=%0d aid=%0d exp iv=1 iid=3 aid=4",
        bus.issue_valid, bus.issue_id, bus.alloc_id);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 0, 0, 0); repeat (7) tick();
    drive(0, 0, 1, 0); repeat (7) tick();
    drive(0, 0, 0, 0); repeat (2) tick();
    n_checks++; if (bus.alloc_id !== 3'd7 || bus.post_issue_count !== 4'd0) begin
      n_fail++; $display("FAIL wrap_setup got aid=%0d post=%0d exp aid=7 post=0", bus.alloc_id, bus.post_issue_count);
    end
    drive(1, 0, 0, 0); repeat (8) tick();
    n_checks++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_full got=%b exp=0", bus.alloc_ready); end
    drive(0, 0, 1, 1); repeat (2) tick();
    drive(0, 0, 0, 0); set_wb(0, 7); set_wb(1, 0); tick();
    drive(0, 0, 0, 0);
    n_checks++; if (bus.alloc_ready !== 1'b0 || bus.retire_valid !== 2'b00) begin
      n_fail++; $display("FAIL wrap_before got rdy=%b rv=%b exp rdy=0 rv=00", bus.alloc_ready, bus.retire_valid);
    end
    tick();
    n_checks++; if (bus.retire_valid !== 2'b11 || bus.retire_ids !== {3'd0, 3'd7} || bus.retire_count !== 2'd2 || bus.alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL wrap_retire got rv=%b ids=%h cnt=%0d rdy=%b exp rv=11 ids=%h cnt=2 rdy=1",
        bus.retire_valid, bus.retire_ids, bus.retire_count, bus.alloc_ready, {3'd0, 3'd7});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 0, 0, 0); repeat (4) tick();
    drive(0, 0, 1, 1); repeat (4) tick();
    n_checks++; if (bus.post_issue_count !== 4'd4) begin n_fail++; $display("FAIL midrst_setup got post=%0d exp=4", bus.post_issue_count); end
    drive(1, 0, 1, 1); set_wb(0, 0); rst = 1'b1; tick();
    rst = 1'b0; drive(0, 0, 0, 0);
    n_checks++; if (bus.post_issue_count !== 4'd0 || bus.retire_valid !== 2'b00 || bus.retire_ids !== {3'd1, 3'd0} ||
                    bus.retire_count !== 2'd0 || bus.alloc_ready !== 1'b1 || bus.issue_valid !== 1'b0 || bus.alloc_id !== 3'd0) begin
      n_fail++; $display("FAIL midrst_state got post=%0d rv=%b ids=%h cnt=%0d rdy=%b iv=%b aid=%0d exp 0,00,%h,0,1,0,0",
        bus.post_issue_count, bus.retire_valid, bus.retire_ids, bus.retire_count, bus.alloc_ready,
        bus.issue_valid, bus.alloc_id, {3'd1, 3'd0});
    end
  endtask

  task automatic test_random();
    int cand[$];
    int k;
    logic [RP-1:0]   e_rv;
    logic [RP*L-1:0] e_ids;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1));
      cand.delete();
      foreach (exp_q[j]) if (m_pend[exp_q[j]]) cand.push_back(exp_q[j]);
      for (int p = 0; p < NWB; p++) begin
        if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
          k = $urandom_range(0, cand.size() - 1);
          set_wb(p, cand[k]);
          cand.delete(k);
        end
      end
      tick();
      e_rv = RP'((1 << m_rn) - 1);
      for (int i = 0; i < RP; i++) e_ids[i*L +: L] = L'((m_base + i) % IDS);
      n_checks++; if (bus.alloc_ready !== ((pre_q.size() + exp_q.size()) < IDS) || bus.alloc_id !== L'(m_next)) begin
        n_fail++; $display("FAIL rnd_alloc cyc=%0d got rdy=%b id=%0d exp rdy=%b id=%0d", cyc, bus.alloc_ready, bus.alloc_id,
          ((pre_q.size() + exp_q.size()) < IDS), m_next);
      end
      n_checks++; if (bus.issue_valid !== (pre_q.size() != 0) || (pre_q.size() != 0 && bus.issue_id !== L'(pre_q[0]))) begin
        n_fail++; $display("FAIL rnd_issue cyc=%0d got v=%b id=%0d exp v=%b", cyc, bus.issue_valid, bus.issue_id, (pre_q.size() != 0));
      end
      n_checks++; if (bus.retire_valid !== e_rv || bus.retire_count !== 2'(m_rn) || bus.retire_ids !== e_ids) begin
        n_fail++; $display("FAIL rnd_retire cyc=%0d got rv=%b cnt=%0d ids=%h exp rv=%b cnt=%0d ids=%h", cyc,
          bus.retire_valid, bus.retire_count, bus.retire_ids, e_rv, m_rn, e_ids);
      end
      n_checks++; if (bus.post_issue_count !== 4'(exp_q.size())) begin
        n_fail++; $display("FAIL rnd_post_count cyc=%0d got=%0d exp=%0d", cyc, bus.post_issue_count, exp_q.size());
      end
    end
    rst = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0);
    test_reset();
    test_alloc_fill();
    test_retire_order();
    test_writeback();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
